// File: rtl/stack_alu_core.sv
// Register-file operand stack with an attached combinational stack ALU.
// One stack operation per rising edge; ALU_out feeds both PUSH/BINOP and branch logic.
module stack_alu_core #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [2:0]       stackOP,
  input  logic [3:0]       aluOP,
  input  logic [WIDTH-1:0] immediate,
  input  logic             mux_selector,
  output logic [WIDTH-1:0] aOut,
  output logic [WIDTH-1:0] bOut,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Overflow,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             err_over,
  output logic             err_under
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE      = CNTW'(1);
  localparam logic [CNTW-1:0] TWO      = CNTW'(2);
  localparam logic [CNTW-1:0] THREE    = CNTW'(3);

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_BINOP, OP_DROP, OP_TEST, OP_SWAP, OP_ROT, OP_CLEAR
  } stack_op_e;

  stack_op_e        op;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNTW-1:0]  cnt;
  logic [AW-1:0]    push_idx, tos_idx, nos_idx, third_idx;
  logic [WIDTH-1:0] tos_val, nos_val, third_val;
  logic [WIDTH-1:0] alu_res, push_val;
  logic             ovf;

  assign op        = stack_op_e'(stackOP);
  assign push_idx  = AW'(cnt);
  assign tos_idx   = AW'(cnt - ONE);
  assign nos_idx   = AW'(cnt - TWO);
  assign third_idx = AW'(cnt - THREE);

  // Unoccupied slots read as zero regardless of stale contents.
  assign tos_val   = (cnt >= ONE)   ? mem[tos_idx]   : '0;
  assign nos_val   = (cnt >= TWO)   ? mem[nos_idx]   : '0;
  assign third_val = (cnt >= THREE) ? mem[third_idx] : '0;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (aluOP)
      4'd0: begin
        alu_res = nos_val + tos_val;
        ovf     = (nos_val[WIDTH-1] == tos_val[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != nos_val[WIDTH-1]);
      end
      4'd1: begin
        alu_res = nos_val - tos_val;
        ovf     = (nos_val[WIDTH-1] != tos_val[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != nos_val[WIDTH-1]);
      end
      4'd2: alu_res = nos_val & tos_val;
      4'd3: alu_res = nos_val | tos_val;
      4'd4: alu_res = nos_val ^ tos_val;
      4'd5: alu_res = tos_val;
      4'd6: alu_res = nos_val;
      4'd7: alu_res = {{(WIDTH-1){1'b0}}, tos_val == nos_val};
      4'd8: alu_res = {{(WIDTH-1){1'b0}}, tos_val == '0};
      4'd9: alu_res = {{(WIDTH-1){1'b0}}, $signed(nos_val) < $signed(tos_val)};
      default: alu_res = '0;
    endcase
  end

  assign push_val = mux_selector ? immediate : alu_res;

  // NOTE: mem is deliberately not reset; cnt alone decides which entries are live.
  // NOTE: non-blocking assignments so every read below sees pre-edge values (SWAP/ROT rely on it).
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt       <= '0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (cnt == FULL_CNT) err_over <= 1'b1;
          else begin
            mem[push_idx] <= push_val;
            cnt           <= cnt + ONE;
          end
        end
        OP_BINOP: begin
          if (cnt < TWO) err_under <= 1'b1;
          else begin
            mem[nos_idx] <= alu_res;
            cnt          <= cnt - ONE;
          end
        end
        OP_DROP: begin
          if (cnt < ONE) err_under <= 1'b1;
          else           cnt       <= cnt - ONE;
        end
        OP_SWAP: begin
          if (cnt < TWO) err_under <= 1'b1;
          else begin
            mem[tos_idx] <= nos_val;
            mem[nos_idx] <= tos_val;
          end
        end
        OP_ROT: begin
          if (cnt < THREE) err_under <= 1'b1;
          else begin
            mem[third_idx] <= nos_val;
            mem[nos_idx]   <= tos_val;
            mem[tos_idx]   <= third_val;
          end
        end
        OP_CLEAR: begin
          cnt       <= '0;
          err_over  <= 1'b0;
          err_under <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign aOut     = tos_val;
  assign bOut     = nos_val;
  assign ALU_out  = alu_res;
  assign Overflow = ovf;
  assign count    = cnt;
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);

endmodule

// File: tb/tb_stack_alu_core.sv
// Scoreboard bench for stack_alu_core: a queue-based stack model predicts every cycle,
// a decoupled monitor compares the DUT outputs on the falling edge.
module tb_stack_alu_core;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, BINOP = 3'd2, DROP = 3'd3,
                         TEST = 3'd4, SWAP = 3'd5, ROT = 3'd6, CLEAR = 3'd7;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    stackOP = NOP;
  logic [3:0]    aluOP = 4'd0;
  logic [W-1:0]  immediate = '0;
  logic          mux_selector = 1'b1;
  logic [W-1:0]  aOut, bOut, ALU_out;
  logic          Overflow;
  logic [CW-1:0] count;
  logic          full, empty, err_over, err_under;

  stack_alu_core #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .reset(reset), .stackOP(stackOP), .aluOP(aluOP),
    .immediate(immediate), .mux_selector(mux_selector),
    .aOut(aOut), .bOut(bOut), .ALU_out(ALU_out), .Overflow(Overflow),
    .count(count), .full(full), .empty(empty),
    .err_over(err_over), .err_under(err_under)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           step;
    logic [W-1:0] a, b, alu;
    logic         ovf;
    int           cnt;
    logic         full, empty, eo, eu;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  // Reference model: the stack as a queue, bottom at index 0.
  logic [W-1:0] mstack[$];
  bit           m_over = 0, m_under = 0;

  function automatic void model_alu(input logic [3:0] aop, output logic [W-1:0] res,
                                    output logic ovf);
    logic [W-1:0] a, b;
    longint sa, sb, r, lo, hi;
    a  = (mstack.size() >= 1) ? mstack[mstack.size()-1] : '0;
    b  = (mstack.size() >= 2) ? mstack[mstack.size()-2] : '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = -(longint'(1) <<< (W-1));
    hi = (longint'(1) <<< (W-1)) - 1;
    r   = 0;
    ovf = 1'b0;
    case (aop)
      4'd0: begin r = sb + sa; ovf = (r < lo) || (r > hi); end
      4'd1: begin r = sb - sa; ovf = (r < lo) || (r > hi); end
      4'd2: r = longint'(b & a);
      4'd3: r = longint'(b | a);
      4'd4: r = longint'(b ^ a);
      4'd5: r = longint'(a);
      4'd6: r = longint'(b);
      4'd7: r = (a == b) ? 1 : 0;
      4'd8: r = (a == 0) ? 1 : 0;
      4'd9: r = (sb < sa) ? 1 : 0;
      default: r = 0;
    endcase
    res = r[W-1:0];
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, step, act, exp);
    end
  endtask

  // Drive one operation for one clock; optionally queue the expected pre-edge outputs.
  task automatic do_op(input bit chk, input bit rst, input logic [2:0] sop,
                       input logic [3:0] aop, input logic [W-1:0] imm, input bit sel);
    exp_t         e;
    logic [W-1:0] res, t;
    logic         ovf;
    int           n;
    @(posedge CLK);
    #1;
    reset = rst; stackOP = sop; aluOP = aop; immediate = imm; mux_selector = sel;
    model_alu(aop, res, ovf);
    n = mstack.size();
    if (chk) begin
      e.step  = step_no;
      e.a     = (n >= 1) ? mstack[n-1] : '0;
      e.b     = (n >= 2) ? mstack[n-2] : '0;
      e.alu   = res;
      e.ovf   = ovf;
      e.cnt   = n;
      e.full  = (n == D);
      e.empty = (n == 0);
      e.eo    = m_over;
      e.eu    = m_under;
      exp_q.push_back(e);
    end
    step_no++;
    if (rst) begin
      mstack.delete(); m_over = 0; m_under = 0;
    end else begin
      case (sop)
        PUSH:  if (n == D) m_over = 1; else mstack.push_back(sel ? imm : res);
        BINOP: if (n < 2) m_under = 1;
               else begin void'(mstack.pop_back()); void'(mstack.pop_back()); mstack.push_back(res); end
        DROP:  if (n < 1) m_under = 1; else void'(mstack.pop_back());
        SWAP:  if (n < 2) m_under = 1;
               else begin t = mstack[n-1]; mstack[n-1] = mstack[n-2]; mstack[n-2] = t; end
        ROT:   if (n < 3) m_under = 1;
               else begin
                 t = mstack[n-3];
                 mstack[n-3] = mstack[n-2];
                 mstack[n-2] = mstack[n-1];
                 mstack[n-1] = t;
               end
        CLEAR: begin mstack.delete(); m_over = 0; m_under = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic push_imm(input logic [W-1:0] v);
    do_op(1, 0, PUSH, 4'd0, v, 1'b1);
  endtask

  task automatic do_rst();
    do_op(1, 1, NOP, 4'd0, '0, 1'b1);
  endtask

  // Monitor: whenever a prediction is pending, compare it against what the DUT shows.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("aOut",      e.step, 32'(aOut),      32'(e.a));
        check("bOut",      e.step, 32'(bOut),      32'(e.b));
        check("ALU_out",   e.step, 32'(ALU_out),   32'(e.alu));
        check("Overflow",  e.step, 32'(Overflow),  32'(e.ovf));
        check("count",     e.step, 32'(count),     32'(e.cnt));
        check("full",      e.step, 32'(full),      32'(e.full));
        check("empty",     e.step, 32'(empty),     32'(e.empty));
        check("err_over",  e.step, 32'(err_over),  32'(e.eo));
        check("err_under", e.step, 32'(err_under), 32'(e.eu));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_op(0, 1, NOP, 4'd0, '0, 1'b1);
    do_op(1, 0, NOP, 4'd3, '0, 1'b1);

    // Arithmetic: subtract, add, signed less-than.
    push_imm(16'd1); push_imm(16'd2);
    do_op(1, 0, BINOP, 4'd1, '0, 1'b1);
    do_op(1, 0, NOP, 4'd8, '0, 1'b1);
    do_rst(); push_imm(16'd1); push_imm(16'd2);
    do_op(1, 0, BINOP, 4'd0, '0, 1'b1);
    do_rst(); push_imm(16'd1); push_imm(16'd2);
    do_op(1, 0, BINOP, 4'd9, '0, 1'b1);
    do_op(1, 0, NOP, 4'd0, '0, 1'b1);

    // Signed overflow on ADD and SUB.
    do_rst(); push_imm(16'h7FFF); push_imm(16'h0001);
    do_op(1, 0, TEST, 4'd0, '0, 1'b1);
    do_op(1, 0, BINOP, 4'd0, '0, 1'b1);
    push_imm(16'h0001);
    do_op(1, 0, TEST, 4'd1, '0, 1'b1);

    // Full and overflow error.
    do_rst();
    for (int i = 1; i <= 4; i++) push_imm(W'(i));
    push_imm(16'd9);
    do_op(1, 0, NOP, 4'd4, '0, 1'b1);

    // Underflow error and CLEAR.
    do_rst(); push_imm(16'd3);
    do_op(1, 0, DROP, 4'd0, '0, 1'b1);
    do_op(1, 0, DROP, 4'd0, '0, 1'b1);
    do_op(1, 0, NOP, 4'd0, '0, 1'b1);
    do_op(1, 0, CLEAR, 4'd0, '0, 1'b1);
    do_op(1, 0, NOP, 4'd0, '0, 1'b1);

    // SWAP, ROT, DUP, OVER.
    push_imm(16'd3); push_imm(16'd7);
    do_op(1, 0, SWAP, 4'd0, '0, 1'b1);
    push_imm(16'd5);
    do_op(1, 0, ROT, 4'd0, '0, 1'b1);
    do_op(1, 0, PUSH, 4'd5, 16'hDEAD, 1'b0);
    do_op(1, 0, DROP, 4'd0, '0, 1'b1);
    do_op(1, 0, PUSH, 4'd6, 16'hBEEF, 1'b0);
    do_op(1, 0, ROT, 4'd2, '0, 1'b1);

    // Branch TEST and reset taking priority over a PUSH.
    do_rst(); push_imm(16'd1); push_imm(16'd1);
    do_op(1, 0, TEST, 4'd7, '0, 1'b1);
    do_op(1, 1, PUSH, 4'd7, 16'd4, 1'b1);
    do_op(1, 0, NOP, 4'd7, '0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [2:0]   sop;
      logic [W-1:0] imm;
      r = $urandom_range(0, 99);
      if      (r < 40) sop = PUSH;
      else if (r < 55) sop = BINOP;
      else if (r < 65) sop = DROP;
      else if (r < 72) sop = TEST;
      else if (r < 80) sop = SWAP;
      else if (r < 88) sop = ROT;
      else if (r < 92) sop = CLEAR;
      else             sop = NOP;
      imm = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
      do_op(1, ($urandom_range(0, 99) < 2), sop, 4'($urandom_range(0, 15)), imm,
            ($urandom_range(0, 3) != 0));
    end

    @(posedge CLK);
    #1;
    stackOP = NOP;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
